// File: rtl/cru_pkg.sv
// Shared definitions for the CRU transaction generator.
//   - cru_state_e : FSM state encoding
//   - DEF_*       : default phase lengths in phi2 cycles
//   - clog2_min1  : counter width helper that never returns 0
package cru_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SAMPLE = 3'd4
    } cru_state_e;

    localparam int DEF_SETTLE = 10;
    localparam int DEF_PULSE  = 2;
    localparam int DEF_HOLD   = 2;

    // Width needed to hold values 0..v-1, but at least one bit.
    function automatic int clog2_min1(input int v);
        if (v <= 1) begin
            return 1;
        end else begin
            return $clog2(v);
        end
    endfunction

endpackage

// File: rtl/cru_phase_timer.sv
// Loadable down-counter used to time each phase of a CRU bit.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   load     : load load_val into the counter this cycle
//   load_val : phase length minus one
//   tc       : terminal count, high while the counter is zero
module cru_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Counter: load has priority, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {W{1'b0}});

endmodule

// File: rtl/cru_xfer_gen.sv
// Multi-bit CRU transaction generator (writes: settle/strobe/hold per bit;
// reads: settle/sample per bit). All outputs are registered.
// Ports:
//   phi2, reset          : clock and asynchronous active-high reset
//   start, rd_nwr        : request and direction (1 = read), sampled in IDLE
//   base_addr, bit_count : address of bit 0 and number of bits (0 => DATA_W)
//   wdata                : write data, bit 0 first
//   cruin                : CRU read data
//   busy, done           : transaction in progress / one-cycle completion
//   rdata                : read result, held until the next start
//   cruout, cruclk       : write bit and active-low write strobe
//   address_bus          : current CRU bit address
module cru_xfer_gen
    import cru_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETTLE = DEF_SETTLE,
    parameter int PULSE  = DEF_PULSE,
    parameter int HOLD   = DEF_HOLD
) (
    input  logic              phi2,
    input  logic              reset,
    input  logic              start,
    input  logic              rd_nwr,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        bit_count,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cruin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              cruout,
    output logic              cruclk,
    output logic [ADDR_W-1:0] address_bus
);

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("cru_xfer_gen: SETTLE must be at least 1");
        end
        if (PULSE < 1) begin : g_bad_pulse
            $error("cru_xfer_gen: PULSE must be at least 1");
        end
        if (HOLD < 1) begin : g_bad_hold
            $error("cru_xfer_gen: HOLD must be at least 1");
        end
    endgenerate

    localparam int MAX_PHASE = (SETTLE > PULSE) ? ((SETTLE > HOLD) ? SETTLE : HOLD)
                                                : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int TMR_W = clog2_min1(MAX_PHASE);
    localparam int IDX_W = clog2_min1(DATA_W);

    // The timer is loaded with length-1 so tc marks the final cycle of a phase.
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    cru_state_e        state_r, state_nx_s;
    logic              tmr_load_s, tmr_tc_s;
    logic [TMR_W-1:0]  tmr_val_s;
    logic              accept_s, advance_s, finish_s, sample_s, last_s;
    logic              busy_nx_s, done_nx_s, cruclk_nx_s;
    logic [IDX_W-1:0]  idx_r, idx_next_s, last_idx_r, last_idx_nx_s;
    logic              rd_r;
    logic [DATA_W-1:0] wdata_r, rdata_r;
    logic [ADDR_W-1:0] address_r;
    logic              cruout_r, cruclk_r, busy_r, done_r;

    cru_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (phi2),
        .rst      (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .tc       (tmr_tc_s)
    );

    assign last_s     = (idx_r == last_idx_r);
    assign idx_next_s = idx_r + IDX_W'(1'b1);

    // Bit count decode: 0 and anything above DATA_W both mean a full word.
    always_comb begin
        if ((bit_count == 5'd0) || (int'(bit_count) > DATA_W)) begin
            last_idx_nx_s = IDX_LAST;
        end else begin
            last_idx_nx_s = IDX_W'(bit_count - 5'd1);
        end
    end

    // State register.
    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic, timer loads and per-bit events.
    always_comb begin
        state_nx_s = state_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = SETTLE_LD;
        accept_s   = 1'b0;
        advance_s  = 1'b0;
        finish_s   = 1'b0;
        sample_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_SETUP;
                    tmr_load_s = 1'b1;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_tc_s && rd_r) begin
                    state_nx_s = ST_SAMPLE;
                end else if (tmr_tc_s) begin
                    state_nx_s = ST_STROBE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PULSE_LD;
                end else begin
                    state_nx_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (tmr_tc_s) begin
                    state_nx_s = ST_HOLD;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_LD;
                end else begin
                    state_nx_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (tmr_tc_s && last_s) begin
                    state_nx_s = ST_IDLE;
                    finish_s   = 1'b1;
                end else if (tmr_tc_s) begin
                    state_nx_s = ST_SETUP;
                    tmr_load_s = 1'b1;
                    advance_s  = 1'b1;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_SAMPLE: begin
                sample_s = 1'b1;
                if (last_s) begin
                    state_nx_s = ST_IDLE;
                    finish_s   = 1'b1;
                end else begin
                    state_nx_s = ST_SETUP;
                    tmr_load_s = 1'b1;
                    advance_s  = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        busy_nx_s   = (state_nx_s != ST_IDLE);
        cruclk_nx_s = (state_nx_s != ST_STROBE);
        done_nx_s   = finish_s;
    end

    // Output and datapath registers: latch on accept, step address/bit on advance.
    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cruclk_r   <= 1'b1;
            cruout_r   <= 1'b0;
            address_r  <= {ADDR_W{1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            rd_r       <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            last_idx_r <= {IDX_W{1'b0}};
        end else begin
            busy_r   <= busy_nx_s;
            done_r   <= done_nx_s;
            cruclk_r <= cruclk_nx_s;
            if (accept_s) begin
                rd_r       <= rd_nwr;
                wdata_r    <= wdata;
                last_idx_r <= last_idx_nx_s;
                idx_r      <= {IDX_W{1'b0}};
                address_r  <= base_addr;
                rdata_r    <= {DATA_W{1'b0}};
                // Reads leave cruout at whatever the last write left behind.
                if (!rd_nwr) begin
                    cruout_r <= wdata[0];
                end else begin
                    cruout_r <= cruout_r;
                end
            end else begin
                if (sample_s) begin
                    rdata_r[idx_r] <= cruin;
                end else begin
                    rdata_r <= rdata_r;
                end
                if (advance_s) begin
                    idx_r     <= idx_next_s;
                    address_r <= address_r + ADDR_W'(1'b1);
                    if (!rd_r) begin
                        cruout_r <= wdata_r[idx_next_s];
                    end else begin
                        cruout_r <= cruout_r;
                    end
                end else begin
                    idx_r <= idx_r;
                end
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign rdata       = rdata_r;
    assign cruout      = cruout_r;
    assign cruclk      = cruclk_r;
    assign address_bus = address_r;

endmodule

// File: tb/tb_cru_xfer_gen.sv
// Directed self-checking bench for cru_xfer_gen with default parameters.
module tb_cru_xfer_gen;

    logic        phi2 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rd_nwr = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic [4:0]  bit_count = 5'd0;
    logic [15:0] wdata = 16'h0000;
    logic        cruin;
    logic        busy, done, cruout, cruclk;
    logic [15:0] rdata, address_bus;

    // Read-side peripheral model: bit value selected by the low address nibble.
    logic [15:0] model = 16'h3C5A;
    assign cruin = model[address_bus[3:0]];

    int tests  = 0;
    int failed = 0;

    // Per-transaction observations.
    logic [15:0] addr_log [0:31];
    logic        out_log  [0:31];
    int          npulse, nlow, nbusy, first_low, done_cyc;
    logic [15:0] rdata_done;
    logic        cruout_done;

    cru_xfer_gen dut (
        .phi2        (phi2),
        .reset       (reset),
        .start       (start),
        .rd_nwr      (rd_nwr),
        .base_addr   (base_addr),
        .bit_count   (bit_count),
        .wdata       (wdata),
        .cruin       (cruin),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .cruout      (cruout),
        .cruclk      (cruclk),
        .address_bus (address_bus)
    );

    always #5 phi2 = ~phi2;

    // Raise start with the given request; return in cycle 1 of the transaction.
    task automatic launch(input logic rd, input logic [15:0] base, input logic [4:0] cnt,
                          input logic [15:0] wd, input logic hold);
        rd_nwr    = rd;
        base_addr = base;
        bit_count = cnt;
        wdata     = wd;
        start     = 1'b1;
        @(posedge phi2); #1;
        if (!hold) start = 1'b0;
    endtask

    // Observe from the current cycle (cycle 1) until done or maxcyc.
    task automatic monitor(input int maxcyc);
        logic prev_clk;
        prev_clk  = 1'b1;
        npulse    = 0;
        nlow      = 0;
        nbusy     = 0;
        first_low = -1;
        done_cyc  = -1;
        for (int c = 1; c <= maxcyc; c++) begin
            if (busy === 1'b1) nbusy++;
            if (cruclk === 1'b0) begin
                nlow++;
                if (first_low < 0) first_low = c;
                if (prev_clk === 1'b1) begin
                    if (npulse < 32) begin
                        addr_log[npulse] = address_bus;
                        out_log[npulse]  = cruout;
                    end
                    npulse++;
                end
            end
            prev_clk = cruclk;
            if (done === 1'b1) begin
                done_cyc    = c;
                rdata_done  = rdata;
                cruout_done = cruout;
                break;
            end
            @(posedge phi2); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (cruclk !== 1'b1) begin failed++; $display("FAIL reset_cruclk: got %b expected 1", cruclk); end
        tests++; if (cruout !== 1'b0) begin failed++; $display("FAIL reset_cruout: got %b expected 0", cruout); end
        tests++; if (address_bus !== 16'h0000) begin failed++; $display("FAIL reset_addr: got %h expected 0000", address_bus); end
        tests++; if (rdata !== 16'h0000) begin failed++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        reset = 1'b0;
        @(posedge phi2); #1;
    endtask

    task automatic test_single_write();
        launch(1'b0, 16'h1000, 5'd1, 16'h0001, 1'b0);
        tests++; if (address_bus !== 16'h1000) begin failed++; $display("FAIL single_addr: got %h expected 1000", address_bus); end
        tests++; if (cruout !== 1'b1) begin failed++; $display("FAIL single_cruout: got %b expected 1", cruout); end
        monitor(40);
        tests++; if (first_low !== 11) begin failed++; $display("FAIL single_first_low: got %0d expected 11", first_low); end
        tests++; if (nlow !== 2) begin failed++; $display("FAIL single_low_cycles: got %0d expected 2", nlow); end
        tests++; if (nbusy !== 14) begin failed++; $display("FAIL single_busy: got %0d expected 14", nbusy); end
        tests++; if (done_cyc !== 15) begin failed++; $display("FAIL single_done: got %0d expected 15", done_cyc); end
        @(posedge phi2); #1;
        tests++; if (done !== 1'b0) begin failed++; $display("FAIL single_done_width: got %b expected 0", done); end
    endtask

    task automatic test_write8();
        logic [7:0] pattern;
        pattern = 8'hA5;
        launch(1'b0, 16'h0020, 5'd8, 16'h00A5, 1'b0);
        monitor(200);
        tests++; if (npulse !== 8) begin failed++; $display("FAIL w8_pulses: got %0d expected 8", npulse); end
        tests++; if (nlow !== 16) begin failed++; $display("FAIL w8_low_cycles: got %0d expected 16", nlow); end
        tests++; if (nbusy !== 112) begin failed++; $display("FAIL w8_busy: got %0d expected 112", nbusy); end
        tests++; if (done_cyc !== 113) begin failed++; $display("FAIL w8_done: got %0d expected 113", done_cyc); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (addr_log[i] !== 16'(16'h0020 + i)) begin failed++; $display("FAIL w8_addr[%0d]: got %h expected %h", i, addr_log[i], 16'(16'h0020 + i)); end
            tests++; if (out_log[i] !== pattern[i]) begin failed++; $display("FAIL w8_cruout[%0d]: got %b expected %b", i, out_log[i], pattern[i]); end
        end
        tests++; if (cruout_done !== 1'b1) begin failed++; $display("FAIL w8_cruout_hold: got %b expected 1", cruout_done); end
    endtask

    task automatic test_read16();
        launch(1'b1, 16'h0100, 5'd0, 16'h0000, 1'b0);
        monitor(250);
        tests++; if (rdata_done !== 16'h3C5A) begin failed++; $display("FAIL r16_rdata: got %h expected 3c5a", rdata_done); end
        tests++; if (nlow !== 0) begin failed++; $display("FAIL r16_cruclk: got %0d low cycles expected 0", nlow); end
        tests++; if (nbusy !== 176) begin failed++; $display("FAIL r16_busy: got %0d expected 176", nbusy); end
        tests++; if (done_cyc !== 177) begin failed++; $display("FAIL r16_done: got %0d expected 177", done_cyc); end
        @(posedge phi2); #1;
        @(posedge phi2); #1;
        tests++; if (rdata !== 16'h3C5A) begin failed++; $display("FAIL r16_rdata_hold: got %h expected 3c5a", rdata); end
    endtask

    task automatic test_read_short();
        launch(1'b1, 16'h0100, 5'd4, 16'h0000, 1'b0);
        monitor(100);
        tests++; if (rdata_done !== 16'h000A) begin failed++; $display("FAIL r4_rdata: got %h expected 000a", rdata_done); end
        tests++; if (nbusy !== 44) begin failed++; $display("FAIL r4_busy: got %0d expected 44", nbusy); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [0:3];
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
        launch(1'b0, 16'hFFFE, 5'd4, 16'h0005, 1'b0);
        monitor(100);
        tests++; if (npulse !== 4) begin failed++; $display("FAIL wrap_pulses: got %0d expected 4", npulse); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (addr_log[i] !== exp_addr[i]) begin failed++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]); end
        end
    endtask

    task automatic test_back_to_back();
        // start held high throughout: the held request must not queue behind the first.
        launch(1'b0, 16'h0040, 5'd2, 16'h0003, 1'b1);
        monitor(100);
        tests++; if (nbusy !== 28) begin failed++; $display("FAIL hs_busy: got %0d expected 28", nbusy); end
        tests++; if (npulse !== 2) begin failed++; $display("FAIL hs_pulses: got %0d expected 2", npulse); end
        tests++; if (done_cyc !== 29) begin failed++; $display("FAIL hs_done: got %0d expected 29", done_cyc); end
        // start still high in the done cycle, so a new transaction begins.
        @(posedge phi2); #1;
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL hs_restart_busy: got %b expected 1", busy); end
        tests++; if (address_bus !== 16'h0040) begin failed++; $display("FAIL hs_restart_addr: got %h expected 0040", address_bus); end
        monitor(100);
        tests++; if (done_cyc !== 29) begin failed++; $display("FAIL hs_restart_done: got %0d expected 29", done_cyc); end
    endtask

    task automatic test_clamp();
        launch(1'b0, 16'h0200, 5'd20, 16'hFFFF, 1'b0);
        monitor(300);
        tests++; if (npulse !== 16) begin failed++; $display("FAIL clamp_pulses: got %0d expected 16", npulse); end
        tests++; if (nbusy !== 224) begin failed++; $display("FAIL clamp_busy: got %0d expected 224", nbusy); end
        tests++; if (done_cyc !== 225) begin failed++; $display("FAIL clamp_done: got %0d expected 225", done_cyc); end
    endtask

    task automatic test_reset_abort();
        launch(1'b0, 16'h0020, 5'd8, 16'h00FF, 1'b0);
        repeat (19) begin @(posedge phi2); #1; end
        tests++; if (address_bus !== 16'h0021) begin failed++; $display("FAIL abort_pre_addr: got %h expected 0021", address_bus); end
        #2 reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL abort_busy: got %b expected 0", busy); end
        tests++; if (cruout !== 1'b0) begin failed++; $display("FAIL abort_cruout: got %b expected 0", cruout); end
        tests++; if (address_bus !== 16'h0000) begin failed++; $display("FAIL abort_addr: got %h expected 0000", address_bus); end
        tests++; if (cruclk !== 1'b1) begin failed++; $display("FAIL abort_cruclk: got %b expected 1", cruclk); end
        @(posedge phi2); #3;
        reset = 1'b0;
        @(posedge phi2); #1;
        monitor(30);
        tests++; if (done_cyc !== -1) begin failed++; $display("FAIL abort_no_done: got done at %0d expected none", done_cyc); end
        tests++; if (nbusy !== 0) begin failed++; $display("FAIL abort_idle: got %0d busy cycles expected 0", nbusy); end
        launch(1'b0, 16'h1000, 5'd1, 16'h0001, 1'b0);
        monitor(40);
        tests++; if (nbusy !== 14) begin failed++; $display("FAIL abort_next_busy: got %0d expected 14", nbusy); end
        tests++; if (done_cyc !== 15) begin failed++; $display("FAIL abort_next_done: got %0d expected 15", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write8();
        test_read16();
        test_read_short();
        test_wrap();
        test_back_to_back();
        test_clamp();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cru_xfer_gen.md
Name: cru_xfer_gen

Overview:
Parametrised CRU transaction generator. It produces multi-bit CRU write (LDCR/SBO/SBZ style) and read (STCR/TB style) cycles on the CRU address, cruout, cruclk and cruin lines. Bit count, settling, strobe width and hold time are configurable. It sits between the mock CPU sequencer and the CRU peripheral decode, and supersedes the single-shot write generator. Start/done handshake is synchronous to phi2.

Parameters:
ADDR_W, 16, width of address_bus and base_addr
DATA_W, 16, maximum bits per transaction; width of wdata/rdata
SETTLE, 10, phi2 cycles of address/cruout settling before strobe or sample (>=1)
PULSE, 2, phi2 cycles cruclk held low on writes (>=1)
HOLD, 2, phi2 cycles address/cruout held after cruclk rises on writes (>=1)

Ports:
phi2  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
rd_nwr  input  1  1 = read transaction, 0 = write; latched on start
base_addr  input  ADDR_W  CRU bit address of bit 0; latched on start
bit_count  input  5  bits to transfer; 0 means DATA_W; values >DATA_W clamp to DATA_W
wdata  input  DATA_W  write data, bit 0 sent first; latched on start
cruin  input  1  CRU read data; synchronous to phi2
busy  output  1  high from the cycle after start accepted until last bit completes
done  output  1  one-cycle pulse after the last bit
rdata  output  DATA_W  read result; valid when done=1, held until next start
cruout  output  1  current write bit
cruclk  output  1  active-low write strobe
address_bus  output  ADDR_W  current CRU bit address

Behaviour:
- Reset (async): state IDLE, busy=0, done=0, cruclk=1, cruout=0, address_bus=0, rdata=0, counters 0. Reset mid-transaction aborts immediately; no done pulse.
- All outputs are registered.
- IDLE: busy=0. start=1 latches the inputs, loads address_bus=base_addr and cruout=wdata[0], clears rdata, and goes to SETUP.
- SETUP: SETTLE cycles. Then go to STROBE on a write, or SAMPLE on a read.
- STROBE (write only): cruclk=0 for PULSE cycles, then HOLD.
- HOLD (write only): cruclk=1 for HOLD cycles. Then advance the bit, or finish.
- SAMPLE (read only): one cycle. cruin is captured into rdata[i] at the end of the cycle. Then advance the bit, or finish.
- Advance: i++, address_bus <= address_bus+1 (modulo 2^ADDR_W, wraps silently), cruout <= wdata[i], then SETUP.
- Finish: return to IDLE with done=1 for exactly one cycle and busy=0.
- Cycles per bit: write SETTLE+PULSE+HOLD (default 14); read SETTLE+1 (default 11). Busy lasts N times that; done is asserted the cycle after.
- cruclk never pulses on reads. cruout holds its last value after a write completes and is not driven by reads (holds).
- start while busy=1: ignored, no queueing.
- start in the done cycle: accepted, since state is IDLE. The new transaction's SETUP begins on the next cycle.
- rdata bits at index >= N read as 0.
- Parameter checks: SETTLE, PULSE and HOLD each <1 is an elaboration error. The phase counter width is clog2 of the largest phase.

Decomposition:
- Package cru_pkg: state encoding (IDLE, SETUP, STROBE, HOLD, SAMPLE) and default timing constants (SETTLE=10, PULSE=2, HOLD=2).
- One sub-module, cru_phase_timer: loadable down-counter with a terminal-count flag, reused for each phase.
- The bit index and address increment stay in the top module.

Test Plan:
- Single-bit write: base=0x1000, count=1, wdata=0x0001 -> address_bus=0x1000, cruout=1; cruclk low exactly on cycles 11-12 after start; busy 14 cycles; done pulse on cycle 15.
- 8-bit write: base=0x0020, count=8, wdata=0x00A5 -> addresses 0x20..0x27; cruout sequence 1,0,1,0,0,1,0,1; 8 cruclk pulses of 2 cycles; done after 112 cycles.
- 16-bit read: count=0, bench drives cruin from a 0x3C5A bit model indexed by address -> rdata=0x3C5A at done; cruclk stays 1; 176 busy cycles.
- Address wrap: base=0xFFFE, count=4 write -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Handshake: start held high throughout a 2-bit write -> second start ignored while busy. Start in the done cycle is accepted, and busy rises next cycle. count=20 clamps to 16.
- Reset asserted at cycle 20 of an 8-bit write -> outputs return to reset values asynchronously; no done; next start after reset behaves normally.
